// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates the shared rectangle drawer between the press mover
// (requester 0) and the garbage mover (requester 1). Each granted request runs an
// erase-old pass followed by a draw-new pass. Before each pass the drawer's pixel
// counters are restarted, and the VGA write is enabled for exactly W*H cycles per pass.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request; ack is combinational and fields are captured
// LOAD_E | one cycle: drawer counters held in reset, erase/old position set up
// ERASE  | N cycles of plot_en with drw_erase=1 and drw_pos=old
// LOAD_D | one cycle: drawer counters held in reset, draw/new position set up
// DRAW   | N cycles of plot_en with drw_erase=0 and drw_pos=new
// DONE   | one cycle: done pulse for the granted requester
module draw_scheduler #(
  parameter int PRESS_W = 40,
  parameter int PRESS_H = 60,
  parameter int GARB_W  = 20,
  parameter int GARB_H  = 20,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       p_req,
  input  logic [2:0] p_old,
  input  logic [2:0] p_new,
  input  logic       p_first,
  output logic       p_ack,
  output logic       p_done,
  input  logic       g_req,
  input  logic [2:0] g_old,
  input  logic [2:0] g_new,
  input  logic       g_first,
  output logic       g_ack,
  output logic       g_done,
  output logic       drw_item,
  output logic       drw_erase,
  output logic [2:0] drw_pos,
  output logic       drw_rst_n,
  output logic       plot_en,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_E = 3'd1,
    S_ERASE  = 3'd2,
    S_LOAD_D = 3'd3,
    S_DRAW   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Terminal counts are elaborated constants so no multiplier is built.
  localparam int                 N_PRESS    = PRESS_W * PRESS_H;
  localparam int                 N_GARB     = GARB_W * GARB_H;
  localparam logic [CNT_W-1:0]   LAST_PRESS = CNT_W'(N_PRESS - 1);
  localparam logic [CNT_W-1:0]   LAST_GARB  = CNT_W'(N_GARB - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             item_q, item_d;
  logic [2:0]       old_q, old_d;
  logic [2:0]       new_q, new_d;
  logic             last_g_q, last_g_d;
  logic             erase_q, erase_d;
  logic [2:0]       pos_q, pos_d;

  logic             grant_p;
  logic             grant_g;
  logic             sel_first;
  logic [2:0]       sel_old;
  logic [2:0]       sel_new;
  logic [CNT_W-1:0] last_cnt;

  // Arbitration, next-state and capture logic; last_g_q=1 means press wins a tie.
  always_comb begin
    grant_p   = p_req & (~g_req | last_g_q);
    grant_g   = g_req & (~p_req | ~last_g_q);
    sel_first = grant_p ? p_first : g_first;
    sel_old   = grant_p ? p_old   : g_old;
    sel_new   = grant_p ? p_new   : g_new;
    last_cnt  = item_q ? LAST_PRESS : LAST_GARB;

    state_d  = state_q;
    cnt_d    = cnt_q;
    item_d   = item_q;
    old_d    = old_q;
    new_d    = new_q;
    last_g_d = last_g_q;
    erase_d  = erase_q;
    pos_d    = pos_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (grant_p || grant_g) begin
          item_d   = grant_p;
          old_d    = sel_old;
          new_d    = sel_new;
          last_g_d = grant_g;
          if (sel_first) begin
            state_d = S_LOAD_D;
            erase_d = 1'b0;
            pos_d   = sel_new;
          end else begin
            state_d = S_LOAD_E;
            erase_d = 1'b1;
            pos_d   = sel_old;
          end
        end
      end
      S_LOAD_E: begin
        state_d = S_ERASE;
        cnt_d   = '0;
      end
      S_ERASE: begin
        if (cnt_q == last_cnt) begin
          state_d = S_LOAD_D;
          cnt_d   = '0;
          erase_d = 1'b0;
          pos_d   = new_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD_D: begin
        state_d = S_DRAW;
        cnt_d   = '0;
      end
      S_DRAW: begin
        if (cnt_q == last_cnt) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and captured-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      item_q   <= 1'b0;
      old_q    <= 3'd0;
      new_q    <= 3'd0;
      last_g_q <= 1'b1;
      erase_q  <= 1'b1;
      pos_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      item_q   <= item_d;
      old_q    <= old_d;
      new_q    <= new_d;
      last_g_q <= last_g_d;
      erase_q  <= erase_d;
      pos_q    <= pos_d;
    end
  end

  // Strobes are gated by reset_n so an asserted reset silences the drawer at once.
  always_comb begin
    p_ack     = reset_n & (state_q == S_IDLE) & grant_p;
    g_ack     = reset_n & (state_q == S_IDLE) & grant_g;
    p_done    = reset_n & (state_q == S_DONE) & item_q;
    g_done    = reset_n & (state_q == S_DONE) & ~item_q;
    plot_en   = reset_n & ((state_q == S_ERASE) | (state_q == S_DRAW));
    drw_rst_n = reset_n & (state_q != S_LOAD_E) & (state_q != S_LOAD_D);
    busy      = reset_n & (state_q != S_IDLE);
    drw_item  = item_q;
    drw_erase = erase_q;
    drw_pos   = pos_q;
  end

endmodule
